att_serial_loader: RTL and testbench

- Downstream of the pulse generator: consumes the 7-bit pre-/post-attenuator settings it drives and loads them into two serial step attenuators.
- The two devices share SCLK/SDATA and have separate latch enables (LE).
- Each setting is reloaded only when it changes, when a reload is forced, or after reset.
- Loads never start while the pulse sequence holds the bus off (hold high), so register updates cannot glitch RF gain mid-shot.

---
 rtl/att_pkg.sv | 16 +
 rtl/att_shift_phy.sv | 145 ++++++++++++++
 rtl/att_serial_loader.sv | 88 ++++++++
 tb/tb_att_serial_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/att_pkg.sv
// Shared types and constants for the serial step-attenuator loader.
package att_pkg;

    localparam int   ATT_W   = 7;
    localparam logic CH_PRE  = 1'b0;
    localparam logic CH_POST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SCLK_LO,
        SCLK_HI,
        LATCH,
        GAP
    } att_state_e;

endpackage

// File: rtl/att_shift_phy.sv
// Serial word engine: shifts one word LSB first on SCLK/SDATA, then strobes
// the selected latch enable and idles for a gap before reporting done.
module att_shift_phy #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WORD_BITS-1:0] word_i,
    input  logic                 sel_i,
    output logic                 sclk_o,
    output logic                 sdata_o,
    output logic                 le_pre_o,
    output logic                 le_post_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 done_sel_o
);
    import att_pkg::*;

    localparam int                BIT_W      = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [7:0]        DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(WORD_BITS - 1);

    att_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 sel_q, sel_d;

    logic sclk_q, sclk_d;
    logic sdata_q, sdata_d;
    logic le_pre_q, le_pre_d;
    logic le_post_q, le_post_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic done_sel_q, done_sel_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            sel_q      <= 1'b0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            le_pre_q   <= 1'b0;
            le_post_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            sel_q      <= sel_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            le_pre_q   <= le_pre_d;
            le_post_q  <= le_post_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_sel_q <= done_sel_d;
        end
    end

    // Outputs are derived from the next state so the registered strobes line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCLK_LO;
                    cnt_d   = DIV_RELOAD;
                    bit_d   = '0;
                    shift_d = word_i;
                    sel_d   = sel_i;
                end
            end
            SCLK_LO: begin
                if (cnt_q == 8'd0) begin
                    state_d = SCLK_HI;
                    cnt_d   = DIV_RELOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SCLK_HI: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = DIV_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d = LATCH;
                    end else begin
                        state_d = SCLK_LO;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            LATCH: begin
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = DIV_RELOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d     = (state_d == SCLK_HI);
        sdata_d    = ((state_d == SCLK_LO) || (state_d == SCLK_HI)) ? shift_d[0] : 1'b0;
        le_pre_d   = (state_d == LATCH) && (sel_d == CH_PRE);
        le_post_d  = (state_d == LATCH) && (sel_d == CH_POST);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == GAP) && (cnt_d == 8'd0);
        done_sel_d = done_d ? sel_d : done_sel_q;
    end

    assign sclk_o     = sclk_q;
    assign sdata_o    = sdata_q;
    assign le_pre_o   = le_pre_q;
    assign le_post_o  = le_post_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign done_sel_o = done_sel_q;

endmodule

// File: rtl/att_serial_loader.sv
// Loads pre/post attenuator codes into two serial step attenuators whenever a
// code changes, a reload is forced, or after reset, never starting inside a pulse window.
module att_serial_loader
    import att_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ATT_W-1:0] pre_att,
    input  logic [ATT_W-1:0] post_att,
    input  logic             hold,
    input  logic             load_all,
    output logic             att_sclk,
    output logic             att_sdata,
    output logic             att_le_pre,
    output logic             att_le_post,
    output logic             busy,
    output logic             done,
    output logic             done_sel
);

    logic [ATT_W-1:0]     shadow_pre_q, shadow_pre_d;
    logic [ATT_W-1:0]     shadow_post_q, shadow_post_d;
    logic                 dirty_pre_q, dirty_pre_d;
    logic                 dirty_post_q, dirty_post_d;
    logic                 start;
    logic                 sel;
    logic [WORD_BITS-1:0] word;
    logic                 phy_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_pre_q  <= '0;
            shadow_post_q <= '0;
            dirty_pre_q   <= 1'b1;
            dirty_post_q  <= 1'b1;
        end else begin
            shadow_pre_q  <= shadow_pre_d;
            shadow_post_q <= shadow_post_d;
            dirty_pre_q   <= dirty_pre_d;
            dirty_post_q  <= dirty_post_d;
        end
    end

    // hold only gates the start of a word; a channel stays dirty until its own word begins.
    always_comb begin
        sel   = dirty_pre_q ? CH_PRE : CH_POST;
        start = !phy_busy && !hold && (dirty_pre_q || dirty_post_q);
        word  = (sel == CH_PRE) ? WORD_BITS'(pre_att) : WORD_BITS'(post_att);

        shadow_pre_d  = shadow_pre_q;
        shadow_post_d = shadow_post_q;
        dirty_pre_d   = dirty_pre_q  || (pre_att  != shadow_pre_q)  || load_all;
        dirty_post_d  = dirty_post_q || (post_att != shadow_post_q) || load_all;

        if (start && (sel == CH_PRE)) begin
            shadow_pre_d = pre_att;
            dirty_pre_d  = 1'b0;
        end
        if (start && (sel == CH_POST)) begin
            shadow_post_d = post_att;
            dirty_post_d  = 1'b0;
        end
    end

    att_shift_phy #(
        .CLK_DIV   (CLK_DIV),
        .WORD_BITS (WORD_BITS)
    ) u_phy (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .word_i     (word),
        .sel_i      (sel),
        .sclk_o     (att_sclk),
        .sdata_o    (att_sdata),
        .le_pre_o   (att_le_pre),
        .le_post_o  (att_le_post),
        .busy_o     (phy_busy),
        .done_o     (done),
        .done_sel_o (done_sel)
    );

    assign busy = phy_busy;

endmodule

// File: tb/tb_att_serial_loader.sv
// Bench for att_serial_loader: models the two attenuator devices and checks
// every loaded word against the set of words the loading rules call for.
module tb_att_serial_loader;

    localparam int DIV = 2;

    typedef struct {
        logic       ch;
        logic [7:0] data;
        int         nbits;
        int         lew;
        int         firstSclk;
    } wordRec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] pre_att = 7'h15;
    logic [6:0] post_att = 7'h40;
    logic       hold = 1'b0;
    logic       load_all = 1'b0;

    logic att_sclk, att_sdata, att_le_pre, att_le_post, busy, done, done_sel;
    logic sclk1, sdata1, lePre1, lePost1, busy1, done1, doneSel1;

    int totalChecks = 0;
    int badChecks = 0;
    int cyc = 0;

    wordRec_t seenQ[$];
    wordRec_t expQ[$];
    int       doneCycQ[$];
    logic     doneSelQ[$];
    int       riseQ[$];

    int         monBits = 0;
    int         firstSclk = 0;
    logic [7:0] shiftBuf = '0;
    int         leRun = 0;
    logic       leCh = 1'b0;
    int         hiRun = 0;
    int         sclkRises = 0;
    int         busyCycles = 0;
    int         bothLe = 0;
    logic       prevSclk = 1'b0;
    logic       prevBusy = 1'b0;
    logic [6:0] devicePre = '0;
    logic [6:0] devicePost = '0;

    int   firstRise1 = -1;
    int   firstDone1 = -1;
    int   hiRun1 = 0;
    int   longHigh1 = 0;
    int   sclk1Rises = 0;
    logic prevSclk1 = 1'b0;
    logic prevBusy1 = 1'b0;

    logic [6:0] curPre = 7'h15;
    logic [6:0] curPost = 7'h40;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    att_serial_loader #(.CLK_DIV(DIV), .WORD_BITS(8)) dut (
        .clk(clk), .reset(reset), .pre_att(pre_att), .post_att(post_att),
        .hold(hold), .load_all(load_all), .att_sclk(att_sclk), .att_sdata(att_sdata),
        .att_le_pre(att_le_pre), .att_le_post(att_le_post), .busy(busy),
        .done(done), .done_sel(done_sel)
    );

    att_serial_loader #(.CLK_DIV(1), .WORD_BITS(8)) dutFast (
        .clk(clk), .reset(reset), .pre_att(pre_att), .post_att(post_att),
        .hold(hold), .load_all(load_all), .att_sclk(sclk1), .att_sdata(sdata1),
        .att_le_pre(lePre1), .att_le_post(lePost1), .busy(busy1),
        .done(done1), .done_sel(doneSel1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Device-side view of the bus: shift on SCLK rise, latch on LE, log every event with its cycle.
    always @(negedge clk) begin
        if (reset) begin
            monBits = 0;
            leRun = 0;
            hiRun = 0;
        end else begin
            if (att_sclk && !prevSclk) begin
                if (monBits == 0) firstSclk = cyc;
                if (monBits < 8) shiftBuf[monBits[2:0]] = att_sdata;
                monBits++;
                sclkRises++;
            end
            if (att_sclk) begin
                hiRun++;
            end else if (prevSclk) begin
                checkOutput("sclk high width", hiRun, DIV);
                hiRun = 0;
            end
            if (att_le_pre || att_le_post) begin
                leRun++;
                leCh = att_le_post;
                if (att_le_pre && att_le_post) bothLe++;
            end else if (leRun > 0) begin
                seenQ.push_back('{ch: leCh, data: shiftBuf, nbits: monBits, lew: leRun, firstSclk: firstSclk});
                if (leCh) devicePost = shiftBuf[6:0];
                else devicePre = shiftBuf[6:0];
                monBits = 0;
                leRun = 0;
            end
            if (done) begin
                doneCycQ.push_back(cyc);
                doneSelQ.push_back(done_sel);
            end
            if (busy && !prevBusy) riseQ.push_back(cyc);
            if (busy) busyCycles++;
        end
        prevSclk = att_sclk;
        prevBusy = busy;
    end

    always @(negedge clk) begin
        if (reset) begin
            hiRun1 = 0;
        end else begin
            if (busy1 && !prevBusy1 && firstRise1 < 0) firstRise1 = cyc;
            if (done1 && firstDone1 < 0) firstDone1 = cyc;
            if (sclk1 && !prevSclk1) sclk1Rises++;
            if (sclk1) begin
                hiRun1++;
                if (hiRun1 > 1) longHigh1++;
            end else begin
                hiRun1 = 0;
            end
        end
        prevSclk1 = sclk1;
        prevBusy1 = busy1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int maxCyc);
        int idleRun = 0;
        bit ok = 0;
        for (int i = 0; i < maxCyc; i++) begin
            tick();
            if (!busy) idleRun++;
            else idleRun = 0;
            if (idleRun >= 4) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("idle timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [6:0] newPre, input logic [6:0] newPost,
                                 input logic doLoad, input int holdCycles);
        int rises0;
        int busy0;
        if (holdCycles > 0) hold = 1'b1;
        pre_att = newPre;
        post_att = newPost;
        load_all = doLoad;
        tick();
        load_all = 1'b0;
        if (holdCycles > 0) begin
            rises0 = sclkRises;
            busy0 = busyCycles;
            repeat (holdCycles) tick();
            checkOutput("sclk quiet under hold", sclkRises, rises0);
            checkOutput("busy quiet under hold", busyCycles, busy0);
            hold = 1'b0;
        end
        tick();
        waitIdle(400);
    endtask

    // Compares the words and done pulses logged since the marks against expQ, in order.
    task automatic checkWords(input string tag, input int wMark, input int dMark);
        int n;
        checkOutput({tag, " word count"}, seenQ.size() - wMark, expQ.size());
        checkOutput({tag, " done count"}, doneCycQ.size() - dMark, expQ.size());
        n = expQ.size();
        if (seenQ.size() - wMark < n) n = seenQ.size() - wMark;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " channel"}, 32'(seenQ[wMark + i].ch), 32'(expQ[i].ch));
            checkOutput({tag, " data"}, 32'(seenQ[wMark + i].data), 32'(expQ[i].data));
            checkOutput({tag, " bit count"}, seenQ[wMark + i].nbits, 8);
            checkOutput({tag, " le width"}, seenQ[wMark + i].lew, DIV);
        end
        n = expQ.size();
        if (doneCycQ.size() - dMark < n) n = doneCycQ.size() - dMark;
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " done_sel"}, 32'(doneSelQ[dMark + i]), 32'(expQ[i].ch));
        end
    endtask

    task automatic pushExp(input logic ch, input logic [6:0] code);
        expQ.push_back('{ch: ch, data: {1'b0, code}, nbits: 8, lew: DIV, firstSclk: 0});
    endtask

    initial begin
        int wm, dm, rm, c0, startEdge;
        logic [6:0] np, nq;
        logic la;
        int hl;

        repeat (3) tick();
        checkOutput("reset outputs", {att_sclk, att_sdata, att_le_pre, att_le_post, busy, done, done_sel}, 0);

        // Power-up: both channels load, pre first, then post back to back.
        wm = seenQ.size(); dm = doneCycQ.size(); rm = riseQ.size();
        c0 = cyc;
        reset = 1'b0;
        waitIdle(400);
        expQ.delete();
        pushExp(1'b0, 7'h15);
        pushExp(1'b1, 7'h40);
        checkWords("powerup", wm, dm);
        checkOutput("powerup bytes", {seenQ[wm].data, seenQ[wm + 1].data}, 16'h1540);
        if (riseQ.size() >= rm + 2 && doneCycQ.size() >= dm + 2 && seenQ.size() >= wm + 1) begin
            checkOutput("start latency", riseQ[rm], c0 + 1);
            checkOutput("first sclk rise", seenQ[wm].firstSclk - riseQ[rm], DIV);
            checkOutput("word length", doneCycQ[dm] - riseQ[rm], 18 * DIV - 1);
            checkOutput("back to back", riseQ[rm + 1] - doneCycQ[dm], 2);
        end else begin
            checkOutput("powerup events", riseQ.size() - rm, 2);
        end
        checkOutput("fast word length", firstDone1 - firstRise1, 17);
        checkOutput("fast sclk rises", sclk1Rises, 16);
        checkOutput("device pre", devicePre, 7'h15);
        checkOutput("device post", devicePost, 7'h40);

        // Change post under hold; the word must start the cycle after hold drops.
        wm = seenQ.size(); dm = doneCycQ.size(); rm = riseQ.size();
        hold = 1'b1;
        post_att = 7'h7F;
        c0 = sclkRises; hl = busyCycles;
        repeat (100) tick();
        checkOutput("hold sclk quiet", sclkRises, c0);
        checkOutput("hold busy low", busyCycles, hl);
        hold = 1'b0;
        c0 = cyc;
        waitIdle(400);
        expQ.delete();
        pushExp(1'b1, 7'h7F);
        checkWords("hold release", wm, dm);
        if (riseQ.size() > rm) checkOutput("hold release start", riseQ[rm], c0 + 1);
        else checkOutput("hold release start", 0, 1);
        curPost = 7'h7F;

        // Pre changes mid-word; the running word is untouched and a reload follows.
        wm = seenQ.size(); dm = doneCycQ.size(); rm = riseQ.size();
        pre_att = 7'h01;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy && monBits == 3) break;
        end
        checkOutput("reached bit 3", monBits, 3);
        pre_att = 7'h02;
        waitIdle(400);
        expQ.delete();
        pushExp(1'b0, 7'h01);
        pushExp(1'b0, 7'h02);
        checkWords("midword change", wm, dm);
        if (riseQ.size() >= rm + 2 && doneCycQ.size() > dm)
            checkOutput("reload gap", riseQ[rm + 1] - doneCycQ[dm], 2);
        else
            checkOutput("reload events", riseQ.size() - rm, 2);
        curPre = 7'h02;

        // load_all with unchanged codes reloads both channels.
        wm = seenQ.size(); dm = doneCycQ.size();
        applyStimulus(curPre, curPost, 1'b1, 0);
        expQ.delete();
        pushExp(1'b0, curPre);
        pushExp(1'b1, curPost);
        checkWords("load_all", wm, dm);

        // Reset mid-word aborts without a latch, then both channels reload.
        wm = seenQ.size(); rm = riseQ.size();
        pre_att = 7'h33;
        curPre = 7'h33;
        startEdge = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (riseQ.size() > rm) begin
                startEdge = riseQ[rm];
                break;
            end
        end
        checkOutput("abort word started", startEdge >= 0, 1);
        for (int i = 0; i < 50; i++) begin
            if (cyc >= startEdge + 18) break;
            tick();
        end
        reset = 1'b1;
        tick();
        checkOutput("abort outputs", {att_sclk, att_sdata, att_le_pre, att_le_post, busy, done, done_sel}, 0);
        checkOutput("abort no latch", seenQ.size(), wm);
        tick();
        wm = seenQ.size(); dm = doneCycQ.size();
        reset = 1'b0;
        waitIdle(400);
        expQ.delete();
        pushExp(1'b0, curPre);
        pushExp(1'b1, curPost);
        checkWords("after abort", wm, dm);

        // Random code changes, forced reloads and hold windows.
        for (int it = 0; it < 12; it++) begin
            np = ($urandom_range(0, 3) == 0) ? curPre : 7'($urandom_range(0, 127));
            nq = ($urandom_range(0, 3) == 0) ? curPost : 7'($urandom_range(0, 127));
            la = ($urandom_range(0, 3) == 0);
            hl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 40));
            expQ.delete();
            if (np != curPre || la) pushExp(1'b0, np);
            if (nq != curPost || la) pushExp(1'b1, nq);
            wm = seenQ.size(); dm = doneCycQ.size();
            applyStimulus(np, nq, la, hl);
            checkWords("random", wm, dm);
            curPre = np;
            curPost = nq;
            checkOutput("random device pre", devicePre, curPre);
            checkOutput("random device post", devicePost, curPost);
        end

        checkOutput("no dual latch", bothLe, 0);
        checkOutput("fast sclk high 1 cycle", longHigh1, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
